// File: rtl/riffa_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riffa_pkg
// Description : Shared constants and types for the RIFFA TX sender.
//               Provides the TX FSM state encoding, the RIFFA word width and
//               the zero-pad width used to build CHNL_TX_LEN from the
//               default transaction length width.
// Revision    : 1.0 - initial release
// ============================================================================
package riffa_pkg;

    // RIFFA counts lengths and offsets in 32-bit words.
    localparam int RIFFA_WORD_W = 32;

    // Default width of the 128-bit word count and the matching zero pad
    // that makes {pad, len, 2'b00} exactly one RIFFA word wide.
    localparam int RIFFA_LEN_W     = 20;
    localparam int RIFFA_LEN_PAD_W = RIFFA_WORD_W - RIFFA_LEN_W - 2;

    // Bit 0 marks the states in which the channel request is held high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_XFER = 2'b11,
        ST_DONE = 2'b10
    } tx_state_t;

endpackage : riffa_pkg
`default_nettype wire

// File: rtl/tx_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_fwft
// Description : Small first-word-fall-through FIFO. The head word is read
//               straight from the register array, so it is valid in the
//               same cycle that empty is low.
// Ports       : clk, rst (async, active-high)
//               flush      - synchronous clear of both pointers
//               push       - write push_data (ignored when full)
//               pop        - discard head (ignored when empty)
//               head       - current head word
//               empty/full - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo_fwft #(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [c_AW:0]           r_wptr;
    logic [c_AW:0]           r_rptr;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic                    w_do_push;
    logic                    w_do_pop;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign head = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[c_AW-1:0]] <= push_data;
                r_wptr                  <= r_wptr + (c_AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (c_AW+1)'(1);
            end
        end
    end

endmodule : tx_fifo_fwft
`default_nettype wire

// File: rtl/riffa_tx_sender.sv
`default_nettype none
// ============================================================================
// Module      : riffa_tx_sender
// Description : Sends one host-bound RIFFA TX transaction per start command.
//               A valid/ready word stream is buffered in a FWFT FIFO and
//               then handed to the RIFFA CHNL_TX request/ack, data/ren
//               interface. Build macro TX_WORD_SWAP_EN reverses the 32-bit
//               lane order of chnl_tx_data.
// Ports       : clk, rst (async, active-high)
//               start, num_words     - command and length (128-bit words)
//               busy, done           - status; done is a one-cycle pulse
//               s_data/valid/ready   - input word stream
//               chnl_tx*             - RIFFA CHNL_TX endpoint interface
// Revision    : 1.0 - initial release
// ============================================================================
module riffa_tx_sender
    import riffa_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = RIFFA_LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  chnl_tx,
    input  logic                  chnl_tx_ack,
    output logic                  chnl_tx_last,
    output logic [31:0]           chnl_tx_len,
    output logic [30:0]           chnl_tx_off,
    output logic [DATA_WIDTH-1:0] chnl_tx_data,
    output logic                  chnl_tx_data_valid,
    input  logic                  chnl_tx_data_ren
);

    localparam int c_LEN_PAD_W = RIFFA_WORD_W - LEN_WIDTH - 2;

    tx_state_t              r_state;
    logic [LEN_WIDTH-1:0]   r_len_q;
    logic [LEN_WIDTH-1:0]   r_in_cnt;
    logic [LEN_WIDTH-1:0]   r_out_cnt;
    logic                   r_zero_done;

    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic [DATA_WIDTH-1:0]  w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_active;

    // Every term here is a register, so ren never reaches s_ready.
    assign w_active = (r_state == ST_REQ) || (r_state == ST_XFER);
    assign s_ready  = !w_fifo_full && (r_in_cnt != r_len_q) && w_active;
    assign w_push   = s_valid && s_ready;

    assign chnl_tx_data_valid = !w_fifo_empty && (r_state == ST_XFER);
    assign w_pop              = chnl_tx_data_valid && chnl_tx_data_ren;

    assign busy         = (r_state != ST_IDLE);
    assign chnl_tx      = w_active;
    assign done         = (r_state == ST_DONE) || r_zero_done;
    assign chnl_tx_last = 1'b1;
    assign chnl_tx_off  = '0;
    assign chnl_tx_len  = {{c_LEN_PAD_W{1'b0}}, r_len_q, 2'b00};

    tx_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (r_state == ST_IDLE),
        .push      (w_push),
        .push_data (s_data),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len_q     <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= 1'b0;

            // Pushes and pops only happen in REQ/XFER; the compares with
            // r_len_q stop both counters at the transaction length.
            if (w_push) begin
                r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            r_len_q   <= num_words;
                            r_in_cnt  <= '0;
                            r_out_cnt <= '0;
                            r_state   <= ST_REQ;
                        end else begin
                            // Empty transaction: report completion without
                            // ever raising the channel request.
                            r_zero_done <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (chnl_tx_ack) begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_pop && (r_out_cnt == r_len_q - LEN_WIDTH'(1))) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TX_WORD_SWAP_EN
    localparam int c_LANES = DATA_WIDTH / RIFFA_WORD_W;

    for (genvar i = 0; i < c_LANES; i++) begin : g_lane_swap
        assign chnl_tx_data[i*RIFFA_WORD_W +: RIFFA_WORD_W] =
            w_head[(c_LANES-1-i)*RIFFA_WORD_W +: RIFFA_WORD_W];
    end
`else
    assign chnl_tx_data = w_head;
`endif

endmodule : riffa_tx_sender
`default_nettype wire

// File: tb/tb_riffa_tx_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_riffa_tx_sender
// Description : Self-checking bench for riffa_tx_sender. A per-cycle driver
//               plays the stream source and the RIFFA endpoint; scenario
//               tasks compare the collected beats against the words that
//               were offered, in order, with the lane swap applied when
//               TX_WORD_SWAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riffa_tx_sender;

    localparam int BUDGET = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [19:0]  num_words;
    logic         busy;
    logic         done;
    logic [127:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         chnl_tx;
    logic         chnl_tx_ack;
    logic         chnl_tx_last;
    logic [31:0]  chnl_tx_len;
    logic [30:0]  chnl_tx_off;
    logic [127:0] chnl_tx_data;
    logic         chnl_tx_data_valid;
    logic         chnl_tx_data_ren;

    int errors = 0;
    int checks = 0;

    logic [127:0] sent[$];
    logic [127:0] got_q[$];
    int           done_cnt, done_tx, ready_over, tx_low_beats, acc_at_rel;
    logic [31:0]  len_seen;
    bit           ready_at_rel, timeout;

    riffa_tx_sender dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .num_words          (num_words),
        .busy               (busy),
        .done               (done),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .chnl_tx            (chnl_tx),
        .chnl_tx_ack        (chnl_tx_ack),
        .chnl_tx_last       (chnl_tx_last),
        .chnl_tx_len        (chnl_tx_len),
        .chnl_tx_off        (chnl_tx_off),
        .chnl_tx_data       (chnl_tx_data),
        .chnl_tx_data_valid (chnl_tx_data_valid),
        .chnl_tx_data_ren   (chnl_tx_data_ren)
    );

    always #5 clk = ~clk;

    // Word the endpoint should see for a given stream word.
    function automatic logic [127:0] exp_word(input logic [127:0] w);
`ifdef TX_WORD_SWAP_EN
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = w[(3-i)*32 +: 32];
        return r;
`else
        return w;
`endif
    endfunction

    task automatic fill_sent(input int n);
        sent.delete();
        for (int i = 0; i < n; i++)
            sent.push_back({$urandom, $urandom, $urandom, $urandom});
    endtask

    // Issue one command and act as source and endpoint each cycle. All
    // decisions are taken on the falling edge; a handshake is recorded when
    // both sides are high there, since it completes at the next rising edge.
    task automatic run_txn(input int n, input int ack_dly, input int vpct,
                           input int rpct, input int ren_hold,
                           input int abort_at, output bit aborted);
        int  cyc, in_idx, tx_cyc, ack_cyc, post_done;
        bit  tx_seen, ack_done;
        got_q.delete();
        done_cnt = 0; done_tx = 0; ready_over = 0; tx_low_beats = 0;
        acc_at_rel = -1; ready_at_rel = 1'b0; len_seen = '0; timeout = 1'b0;
        aborted = 1'b0; in_idx = 0; tx_seen = 0; ack_done = 0;
        tx_cyc = 0; ack_cyc = 0; post_done = -1;
        @(negedge clk);
        start = 1'b1; num_words = 20'(n);
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < BUDGET; cyc++) begin
            if (abort_at > 0 && got_q.size() == abort_at) begin
                aborted = 1'b1;
                return;
            end
            if (done) begin
                done_cnt++;
                if (chnl_tx) done_tx++;
                if (post_done < 0) post_done = cyc;
            end
            if (post_done >= 0 && cyc >= post_done + 3) break;
            if (chnl_tx && !tx_seen) begin
                tx_seen = 1; tx_cyc = cyc; len_seen = chnl_tx_len;
            end
            chnl_tx_ack = 1'b0;
            if (tx_seen && !ack_done && (cyc - tx_cyc) == ack_dly) begin
                chnl_tx_ack = 1'b1; ack_done = 1; ack_cyc = cyc;
            end
            if (ren_hold > 0 && ack_done && (cyc - ack_cyc) == ren_hold + 1) begin
                acc_at_rel = in_idx; ready_at_rel = s_ready;
            end
            if (ack_done && (cyc - ack_cyc) <= ren_hold)
                chnl_tx_data_ren = 1'b0;
            else
                chnl_tx_data_ren = ($urandom_range(99) < rpct);
            s_valid = ($urandom_range(99) < vpct);
            s_data  = (in_idx < n) ? sent[in_idx] : {4{32'hDEADBEEF}};
            if (s_ready && in_idx >= n) ready_over++;
            if (s_valid && s_ready && in_idx < n) in_idx++;
            if (chnl_tx_data_valid && chnl_tx_data_ren) begin
                got_q.push_back(chnl_tx_data);
                if (!chnl_tx) tx_low_beats++;
            end
            @(negedge clk);
        end
        if (cyc >= BUDGET) timeout = 1'b1;
        s_valid = 1'b0; chnl_tx_data_ren = 1'b0; chnl_tx_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; num_words = '0; s_data = '0; s_valid = 1'b0;
        chnl_tx_ack = 1'b0; chnl_tx_data_ren = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, s_ready, chnl_tx, chnl_tx_data_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, s_ready, chnl_tx, chnl_tx_data_valid});
        end
        checks++; if (chnl_tx_last !== 1'b1) begin
            errors++; $display("FAIL reset_last got=%b exp=1", chnl_tx_last);
        end
        checks++; if ({chnl_tx_len, chnl_tx_off, chnl_tx_data} !== '0) begin
            errors++; $display("FAIL reset_buses got len=%0h off=%0h data=%0h exp=0", chnl_tx_len, chnl_tx_off, chnl_tx_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_txn(input string name, input int n, input bit chk_len);
        checks++; if (timeout !== 1'b0) begin
            errors++; $display("FAIL %s_timeout no completion within %0d cycles", name, BUDGET);
        end
        if (chk_len) begin
            checks++; if (len_seen !== 32'(n * 4)) begin
                errors++; $display("FAIL %s_len got=%0d exp=%0d", name, len_seen, n * 4);
            end
        end
        checks++; if (got_q.size() != n) begin
            errors++; $display("FAIL %s_beats got=%0d exp=%0d", name, got_q.size(), n);
        end
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_word(sent[i])) begin
                errors++; $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, got_q[i], exp_word(sent[i]));
            end
        end
        checks++; if (done_cnt != 1 || done_tx != 0) begin
            errors++; $display("FAIL %s_done got pulses=%0d with_tx=%0d exp=1/0", name, done_cnt, done_tx);
        end
        checks++; if (ready_over != 0 || tx_low_beats != 0) begin
            errors++; $display("FAIL %s_overrun got extra_ready=%0d beats_without_tx=%0d exp=0/0", name, ready_over, tx_low_beats);
        end
    endtask

    task automatic test_basic;
        bit ab;
        fill_sent(3);
        run_txn(3, 2, 100, 100, 0, 0, ab);
        check_txn("basic", 3, 1'b1);
    endtask

    task automatic test_backpressure;
        bit ab;
        fill_sent(8);
        run_txn(8, 2, 100, 100, 10, 0, ab);
        checks++; if (acc_at_rel != 4 || ready_at_rel !== 1'b0) begin
            errors++; $display("FAIL bp_fill got accepted=%0d s_ready=%b exp=4/0", acc_at_rel, ready_at_rel);
        end
        check_txn("bp", 8, 1'b1);
    endtask

    task automatic test_random;
        bit ab;
        fill_sent(100);
        run_txn(100, 1, 60, 50, 0, 0, ab);
        check_txn("rand", 100, 1'b1);
    endtask

    task automatic test_zero;
        int d = 0, t = 0, b = 0;
        @(negedge clk);
        start = 1'b1; num_words = '0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || chnl_tx !== 1'b0) begin
            errors++; $display("FAIL zero_pulse got done=%b busy=%b tx=%b exp=1/0/0", done, busy, chnl_tx);
        end
        repeat (5) begin
            @(negedge clk);
            d += int'(done); t += int'(chnl_tx); b += int'(busy);
        end
        checks++; if (d != 0 || t != 0 || b != 0) begin
            errors++; $display("FAIL zero_after got done=%0d tx=%0d busy=%0d exp=0/0/0", d, t, b);
        end
    endtask

    task automatic test_reset_mid;
        bit ab;
        int d = 0;
        fill_sent(5);
        run_txn(5, 1, 100, 100, 0, 2, ab);
        checks++; if (ab !== 1'b1) begin
            errors++; $display("FAIL rmid_reach got beats=%0d exp=2", got_q.size());
        end
        rst = 1'b1; s_valid = 1'b0; chnl_tx_data_ren = 1'b0; chnl_tx_ack = 1'b0;
        #1;
        checks++; if ({chnl_tx, busy, s_ready, chnl_tx_data_valid, done} !== 5'b0) begin
            errors++; $display("FAIL rmid_async got=%b exp=00000", {chnl_tx, busy, s_ready, chnl_tx_data_valid, done});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            d += int'(done);
        end
        checks++; if (d != 0) begin
            errors++; $display("FAIL rmid_nodone got=%0d exp=0", d);
        end
        fill_sent(2);
        run_txn(2, 2, 100, 100, 0, 0, ab);
        check_txn("rmid_restart", 2, 1'b1);
    endtask

    task automatic test_swap;
        bit ab;
        logic [127:0] exp;
        sent.delete();
        sent.push_back(128'h00000004_00000003_00000002_00000001);
`ifdef TX_WORD_SWAP_EN
        exp = 128'h00000001_00000002_00000003_00000004;
`else
        exp = 128'h00000004_00000003_00000002_00000001;
`endif
        run_txn(1, 0, 100, 100, 0, 0, ab);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp) begin
            errors++; $display("FAIL swap_data got n=%0d w=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 128'h0, exp);
        end
        checks++; if (len_seen !== 32'd4 || done_cnt != 1) begin
            errors++; $display("FAIL swap_txn got len=%0d done=%0d exp=4/1", len_seen, done_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_random;
        test_zero;
        test_reset_mid;
        test_swap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_riffa_tx_sender
`default_nettype wire
